conv_result_writer: RTL and testbench



---
 rtl/conv_layer_pkg.sv | 30 +++
 rtl/conv_result_writer_if.sv | 22 ++
 rtl/conv_row_fifo.sv | 46 ++++
 rtl/conv_result_writer.sv | 113 +++++++++++
 tb/tb_conv_result_writer.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv_layer_pkg.sv
// Shared constants, types and helpers for the convolution write-back path.
package conv_layer_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ROW_LEN    = 6;
  localparam int unsigned NUM_ROWS   = 6;
  localparam int unsigned ADDR_WIDTH = 6;
  localparam int unsigned BUS_WIDTH  = ROW_LEN * DATA_WIDTH;

  typedef logic [DATA_WIDTH-1:0] pixel_t;
  typedef logic [BUS_WIDTH-1:0]  row_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [2:0]            idx_t;

  localparam idx_t  COL_LAST  = idx_t'(ROW_LEN - 1);
  localparam idx_t  ROWS_MAX  = idx_t'(NUM_ROWS);
  localparam addr_t ROW_LEN_A = addr_t'(ROW_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } wr_state_t;

  // Pixel 0 occupies the most significant lane of the packed row.
  function automatic pixel_t row_pixel(row_t r, idx_t col);
    return r[(ROW_LEN - 1 - int'(col)) * DATA_WIDTH +: DATA_WIDTH];
  endfunction

endpackage

// File: rtl/conv_result_writer_if.sv
// Row handshake from conv_layer_top plus the result RAM write port.
interface conv_result_writer_if;
  import conv_layer_pkg::*;

  logic   i_row_valid;
  row_t   i_pixel_bus;
  logic   o_row_ready;
  addr_t  ram_addr;
  pixel_t ram_wdata;
  logic   ram_we;

  modport master (
    output i_row_valid, i_pixel_bus,
    input  o_row_ready, ram_addr, ram_wdata, ram_we
  );

  modport slave (
    input  i_row_valid, i_pixel_bus,
    output o_row_ready, ram_addr, ram_wdata, ram_we
  );

endinterface

// File: rtl/conv_row_fifo.sv
// Two-entry row FIFO; head_o presents the oldest row while not empty.
module conv_row_fifo
  import conv_layer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic       pop_i,
  input  row_t       data_i,
  output row_t       head_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [1:0] count_o
);

  row_t       mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       do_push;
  logic       do_pop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/conv_result_writer.sv
// Serialises buffered output rows into the 64x32 result RAM, one word per cycle.
// Build option: CONV_WRITER_RELU_EN clamps negative pixels (sign bit set) to zero.
module conv_result_writer
  import conv_layer_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  conv_result_writer_if.slave bus,
  output logic o_busy,
  output logic o_done
);

  // state | meaning
  // IDLE  | waiting for a buffered row (and enable)
  // WRITE | emitting head row, one pixel per enabled cycle
  // DONE  | frame complete: o_done pulse, frame counters cleared

  wr_state_t  state_q, state_d;
  idx_t       col_q, col_d;
  idx_t       row_q, row_d;
  idx_t       acc_q, acc_d;
  logic       rdy_en_q;

  logic       push, pop, we, done;
  logic       full, empty;
  logic [1:0] count;
  row_t       head;
  pixel_t     pix, wdata;

  conv_row_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (bus.i_pixel_bus),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign bus.o_row_ready = rdy_en_q & ~full & (acc_q < ROWS_MAX);
  assign push            = bus.i_row_valid & bus.o_row_ready;

  assign pix = row_pixel(head, col_q);
`ifdef CONV_WRITER_RELU_EN
  assign wdata = pix[DATA_WIDTH-1] ? '0 : pix;
`else
  assign wdata = pix;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      col_q    <= '0;
      row_q    <= '0;
      acc_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      acc_q    <= acc_d;
      rdy_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    acc_d   = acc_q + {2'b00, push};
    pop     = 1'b0;
    we      = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable && !empty) state_d = WRITE;
      end
      WRITE: begin
        if (enable) begin
          we = 1'b1;
          if (col_q == COL_LAST) begin
            pop   = 1'b1;
            col_d = '0;
            row_d = row_q + 3'd1;
            // A row arriving on the same edge as the pop keeps the stream gapless.
            if (row_d == ROWS_MAX)                 state_d = DONE;
            else if (!(count == 2'd2 || push))     state_d = IDLE;
          end else begin
            col_d = col_q + 3'd1;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        col_d   = '0;
        row_d   = '0;
        acc_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ram_we    = we;
  assign bus.ram_addr  = {3'b000, row_q} * ROW_LEN_A + {3'b000, col_q};
  assign bus.ram_wdata = (state_q == WRITE) ? wdata : '0;
  assign o_busy        = (acc_q != 3'd0);
  assign o_done        = done;

endmodule

// File: tb/tb_conv_result_writer.sv
// Directed bench for conv_result_writer with a write scoreboard.
`timescale 1ns/1ps
module tb_conv_result_writer;
  import conv_layer_pkg::*;

  typedef struct packed {
    addr_t  addr;
    pixel_t data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic o_busy, o_done;

  conv_result_writer_if bus();

  conv_result_writer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .bus    (bus),
    .o_busy (o_busy),
    .o_done (o_done)
  );

  initial forever #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  int   cyc = 0;
  int   n_writes = 0;
  int   n_done = 0;
  int   cyc_first0 = 0;
  int   cyc_last35 = 0;
  int   tb_row = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic pixel_t model_px(pixel_t p);
`ifdef CONV_WRITER_RELU_EN
    return p[31] ? 32'h0 : p;
`else
    return p;
`endif
  endfunction

  function automatic row_t row_fill(pixel_t v);
    row_t r;
    for (int c = 0; c < 6; c++) r[(5 - c) * 32 +: 32] = v;
    return r;
  endfunction

  function automatic row_t row_seq(int base);
    row_t r;
    for (int c = 0; c < 6; c++) r[(5 - c) * 32 +: 32] = 32'(base + c);
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.ram_we === 1'b1) begin
        n_writes++;
        if (bus.ram_addr === 6'd0)  cyc_first0 = cyc;
        if (bus.ram_addr === 6'd35) cyc_last35 = cyc;
        if (sb_q.size() == 0) begin
          check("unexpected_write", 32'(bus.ram_addr), 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          check("wr_addr", 32'(bus.ram_addr), 32'(e.addr));
          check("wr_data", bus.ram_wdata, e.data);
        end
      end
      if (rst_n === 1'b1 && o_done === 1'b1) n_done++;
    end
  end

  // Holds i_row_valid until accepted; returns at the negedge after acceptance.
  task automatic send_row(input row_t r);
    bit ok;
    ok = 1'b0;
    bus.i_pixel_bus = r;
    bus.i_row_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      if (bus.o_row_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("row_accept_timeout", 32'(ok), 32'd1);
    if (ok) begin
      @(posedge clk);
      for (int c = 0; c < 6; c++)
        sb_q.push_back('{addr: addr_t'(tb_row * 6 + c), data: model_px(r[(5 - c) * 32 +: 32])});
      tb_row = (tb_row + 1) % 6;
      @(negedge clk);
    end
  endtask

  task automatic wait_done(output int dcyc);
    bit found;
    found = 1'b0;
    dcyc  = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (o_done === 1'b1) begin
        found = 1'b1;
        dcyc  = cyc;
        break;
      end
    end
    check("done_timeout", 32'(found), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(bus.o_row_ready), 32'd0);
    check({tag, "_we"},    32'(bus.ram_we), 32'd0);
    check({tag, "_addr"},  32'(bus.ram_addr), 32'd0);
    check({tag, "_wdata"}, bus.ram_wdata, 32'd0);
    check({tag, "_busy"},  32'(o_busy), 32'd0);
    check({tag, "_done"},  32'(o_done), 32'd0);
  endtask

  // Asserts reset a little after a negedge, i.e. away from any clock edge.
  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 check_reset_values(tag);
    sb_q.delete();
    tb_row = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check({tag, "_ready_after"}, 32'(bus.o_row_ready), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: observed no completion, required completion within 200 us");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int dc, w0, d0, en_cyc;
    bit seen;
    bus.i_row_valid = 1'b0;
    bus.i_pixel_bus = '0;

    // Power-on reset
    #2 check_reset_values("por");
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check("por_ready_before_edge", 32'(bus.o_row_ready), 32'd0);
    @(negedge clk);
    check("por_ready_first_cycle", 32'(bus.o_row_ready), 32'd1);
    enable = 1'b1;

    // Single row of 1.0: six writes on cycles N+1..N+6
    send_row(row_fill(32'h3F80_0000));
    bus.i_row_valid = 1'b0;
    check("t1_we_accept_cycle", 32'(bus.ram_we), 32'd0);
    check("t1_busy", 32'(o_busy), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t1_we", 32'(bus.ram_we), 32'd1);
      check("t1_addr", 32'(bus.ram_addr), 32'(i));
    end
    @(negedge clk);
    check("t1_we_after", 32'(bus.ram_we), 32'd0);
    check("t1_sb_drained", 32'(sb_q.size()), 32'd0);
    do_reset("t1_rst");

    // Full frame, rows held valid back to back, data = address
    w0 = n_writes;
    d0 = n_done;
    for (int r = 0; r < 6; r++) send_row(row_seq(r * 6));
    bus.i_row_valid = 1'b0;
    wait_done(dc);
    check("t2_done_after_addr35", 32'(dc - cyc_last35), 32'd1);
    check("t2_busy_in_done", 32'(o_busy), 32'd1);
    check("t2_gapless_span", 32'(cyc_last35 - cyc_first0), 32'd35);
    check("t2_write_count", 32'(n_writes - w0), 32'd36);
    @(negedge clk);
    check("t2_done_one_pulse", 32'(o_done), 32'd0);
    check("t2_busy_fall", 32'(o_busy), 32'd0);
    check("t2_ready_next_frame", 32'(bus.o_row_ready), 32'd1);
    check("t2_done_count", 32'(n_done - d0), 32'd1);

    // enable dropped for 3 cycles at row 1 col 2 (address 8)
    w0 = n_writes;
    d0 = n_done;
    fork
      begin
        for (int r = 0; r < 6; r++) send_row(row_seq(1000 + r * 6));
        bus.i_row_valid = 1'b0;
      end
      begin
        seen = 1'b0;
        for (int t = 0; t < 200; t++) begin
          @(negedge clk);
          if (bus.ram_we === 1'b1 && bus.ram_addr === 6'd7) begin
            seen = 1'b1;
            break;
          end
        end
        check("t3_reach_addr7", 32'(seen), 32'd1);
        @(posedge clk);
        #1 enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("t3_paused_we", 32'(bus.ram_we), 32'd0);
          check("t3_paused_addr", 32'(bus.ram_addr), 32'd8);
        end
        @(posedge clk);
        #1 enable = 1'b1;
        @(negedge clk);
        check("t3_resume_we", 32'(bus.ram_we), 32'd1);
        check("t3_resume_addr", 32'(bus.ram_addr), 32'd8);
      end
    join
    wait_done(dc);
    check("t3_write_count", 32'(n_writes - w0), 32'd36);
    check("t3_done_count", 32'(n_done - d0), 32'd1);
    @(negedge clk);

    // Writer paused: two rows buffered, third stalls until the first pops
    enable = 1'b0;
    w0 = n_writes;
    d0 = n_done;
    send_row({32'hBF80_0000, 32'h3F80_0000, 32'h8000_0000,
              32'h4000_0000, 32'hC000_0000, 32'h0000_0001});
    send_row(row_seq(3006));
    bus.i_pixel_bus = row_seq(3012);
    bus.i_row_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("t4_ready_stall", 32'(bus.o_row_ready), 32'd0);
      check("t4_we_paused", 32'(bus.ram_we), 32'd0);
      @(negedge clk);
    end
    check("t4_busy", 32'(o_busy), 32'd1);
    en_cyc = cyc;
    enable = 1'b1;
    send_row(row_seq(3012));
    check("t4_third_accept_latency", 32'(cyc - en_cyc), 32'd8);
    for (int r = 3; r < 6; r++) send_row(row_seq(3000 + r * 6));
    bus.i_row_valid = 1'b0;
    wait_done(dc);
    check("t4_write_count", 32'(n_writes - w0), 32'd36);
    check("t4_done_count", 32'(n_done - d0), 32'd1);
    @(negedge clk);

    // Reset mid-frame at address 20
    for (int r = 0; r < 4; r++) send_row(row_seq(4000 + r * 6));
    bus.i_row_valid = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.ram_we === 1'b1 && bus.ram_addr === 6'd20) begin
        seen = 1'b1;
        break;
      end
    end
    check("t5_reach_addr20", 32'(seen), 32'd1);
    d0 = n_done;
    do_reset("t5_rst");
    send_row(row_fill(32'h4040_0000));
    bus.i_row_valid = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus.ram_we === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("t5_new_frame_write", 32'(seen), 32'd1);
    check("t5_new_frame_addr", 32'(bus.ram_addr), 32'd0);
    repeat (8) @(negedge clk);
    check("t5_sb_drained", 32'(sb_q.size()), 32'd0);
    check("t5_no_done_after_reset", 32'(n_done - d0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
